// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : MIPS instruction-fetch stage, PC, and IF/ID pipeline register
// Rev 1.0
// ============================================================================
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [5:0]      id_opcode,
    output logic [PC_W-1:0] id_pc,
    output logic [PC_W-1:0] id_pc_plus4,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    localparam logic [0:0]      c_BOOT    = 1'b0;
    localparam logic [0:0]      c_RUN     = 1'b1;
    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

    logic [0:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_id_valid;
    logic [31:0]     r_id_instr;
    logic [PC_W-1:0] r_id_pc;
    logic [PC_W-1:0] r_id_pc_plus4;
    logic            r_misalign;
    logic [31:0]     r_fetch_count;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_redirect_aligned;

    always_comb begin
        w_pc_plus4         = r_pc + c_PC_STEP;
        w_redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};
        if (reset) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = w_redirect_aligned;
        end else if (r_state == c_BOOT || stall) begin
            // Re-present r_pc so its word is on imem_rdata next cycle.
            imem_addr = r_pc;
        end else begin
            imem_addr = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_BOOT;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= 32'h0;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'h0;
        end else if (redirect_valid) begin
            // Squash the wrong-path instruction even if the hazard unit stalls.
            r_state    <= c_RUN;
            r_pc       <= w_redirect_aligned;
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else if (r_state == c_BOOT) begin
            r_state <= c_RUN;
        end else if (!stall) begin
            r_pc          <= w_pc_plus4;
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rdata;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign id_valid     = r_id_valid;
    assign id_instr     = r_id_instr;
    assign id_opcode    = r_id_instr[31:26];
    assign id_pc        = r_id_pc;
    assign id_pc_plus4  = r_id_pc_plus4;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed + randomized bench for fetch_stage
// Rev 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: word i holds 0x20080000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which address is being read, what ID holds, etc.
    bit          m_init = 0;
    bit          m_boot;
    logic [31:0] m_read_pc;
    bit          m_valid;
    logic [31:0] m_id_pc, m_id_pc4, m_count;
    bit          m_mis;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_boot = 1; m_read_pc = 32'h0; m_valid = 0;
            m_id_pc = 0; m_id_pc4 = 0; m_count = 0; m_mis = 0;
        end else if (m_init) begin
            if (redirect_valid) begin
                m_read_pc = redirect_pc & 32'hFFFF_FFFC;
                m_boot = 0; m_valid = 0;
                if (redirect_pc[1:0] != 0) m_mis = 1;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (!stall) begin
                m_valid   = 1;
                m_id_pc   = m_read_pc;
                m_id_pc4  = m_read_pc + 4;
                m_read_pc = m_read_pc + 4;
                m_count   = m_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_addr, e_instr;
        if (m_init) begin
            if (reset)                e_addr = 32'h0;
            else if (redirect_valid)  e_addr = redirect_pc & 32'hFFFF_FFFC;
            else if (m_boot || stall) e_addr = m_read_pc;
            else                      e_addr = m_read_pc + 4;
            e_instr = m_valid ? mem_word(m_id_pc) : 32'h0;
            chk("imem_addr",    imem_addr,            e_addr);
            chk("id_valid",     {31'b0, id_valid},    {31'b0, m_valid});
            chk("id_instr",     id_instr,             e_instr);
            chk("id_opcode",    {26'b0, id_opcode},   {26'b0, e_instr[31:26]});
            chk("id_pc",        id_pc,                m_id_pc);
            chk("id_pc_plus4",  id_pc_plus4,          m_id_pc4);
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
            chk("fetch_count",  fetch_count,          m_count);
        end
    end

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_pc", id_pc, 32'd0);

        step(0, 0, 0, 0);
        chk("boot_valid", {31'b0, id_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("first_valid", {31'b0, id_valid}, 32'd1);
        chk("first_pc", id_pc, 32'h0);
        chk("first_instr", id_instr, 32'h2008_0000);
        chk("first_opcode", {26'b0, id_opcode}, 32'h8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("seq_pc8", id_pc, 32'h8);
        chk("seq_count", fetch_count, 32'd3);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_count", fetch_count, 32'd3);
            chk("stall_addr", imem_addr, 32'hC);
        end
        step(0, 0, 0, 0);
        chk("release_pc", id_pc, 32'hC);
        step(0, 0, 0, 0);
        chk("release_instr", id_instr, 32'h2008_0004);

        step(0, 1, 1, 32'h40);
        chk("squash_valid", {31'b0, id_valid}, 32'd0);
        chk("squash_instr", id_instr, 32'h0);
        chk("squash_count", fetch_count, 32'd5);
        step(0, 0, 0, 0);
        chk("target_pc", id_pc, 32'h40);
        chk("target_count", fetch_count, 32'd6);

        step(0, 0, 1, 32'h43);
        chk("mis_set", {31'b0, misalign_err}, 32'd1);
        step(0, 0, 0, 0);
        chk("mis_pc", id_pc, 32'h40);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);

        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        step(0, 0, 0, 0);
        chk("wrap_next", id_pc, 32'h0);

        step(1, 0, 1, 32'h100);
        chk("midrst_valid", {31'b0, id_valid}, 32'd0);
        chk("midrst_count", fetch_count, 32'd0);
        chk("midrst_mis", {31'b0, misalign_err}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("restart_pc", id_pc, 32'h0);
        chk("restart_valid", {31'b0, id_valid}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_0FFF);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
